// File: rtl/fpmul_seq.sv
// Sequential fp32 multiplier: radix-2 shift-add mantissa core on adder24,
// exponent on adder10, RNE rounding, flush-to-zero, 26-cycle fixed latency.
module cla_adder #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s_o    = p ^ c[W-1:0];
  assign cout_o = c[W];
endmodule

module adder24 (
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  input  logic        cin_i,
  output logic [23:0] s_o,
  output logic        cout_o
);
  cla_adder #(.W(24)) u_cla (
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .s_o(s_o), .cout_o(cout_o)
  );
endmodule

module adder10 (
  input  logic [9:0] a_i,
  input  logic [9:0] b_i,
  input  logic       cin_i,
  output logic [9:0] s_o,
  output logic       cout_o
);
  cla_adder #(.W(10)) u_cla (
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .s_o(s_o), .cout_o(cout_o)
  );
endmodule

module fpmul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf
);
  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_NORM, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_NUM, C_ZERO, C_INF, C_NAN
  } cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [47:0] p_q, p_d;
  logic [23:0] ma_q, ma_d;
  logic [7:0]  eb_q, eb_d;
  logic [9:0]  e_q, e_d;
  logic        sign_q, sign_d;
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic [23:0] acc_s;
  logic        acc_c;
  logic [9:0]  ex_b;
  logic [9:0]  e_sum;
  logic        e_co_unused;

  adder24 u_macc (
    .a_i(p_q[47:24]), .b_i(ma_q), .cin_i(1'b0),
    .s_o(acc_s), .cout_o(acc_c)
  );

  // First MUL cycle adds eb, second adds -127.
  assign ex_b = (cnt_q == 5'd0) ? {2'b00, eb_q} : 10'h381;

  adder10 u_exp (
    .a_i(e_q), .b_i(ex_b), .cin_i(1'b0),
    .s_o(e_sum), .cout_o(e_co_unused)
  );

  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;

  always_comb begin
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
  end

  logic [22:0] fr;
  logic        grd;
  logic        stk;
  logic [9:0]  en;
  logic [23:0] fr_r;
  logic [9:0]  ef;
  logic [31:0] norm_res;
  logic        norm_ovf;
  logic        norm_unf;

  always_comb begin
    if (p_q[47]) begin
      fr  = p_q[46:24];
      grd = p_q[23];
      stk = |p_q[22:0];
      en  = e_q + 10'd1;
    end else begin
      fr  = p_q[45:23];
      grd = p_q[22];
      stk = |p_q[21:0];
      en  = e_q;
    end
    fr_r     = {1'b0, fr} + 24'(grd & (stk | fr[0]));
    ef       = en + 10'(fr_r[23]);
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    norm_res = {sign_q, ef[7:0], fr_r[22:0]};
    if ($signed(ef) >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'b0};
      norm_ovf = 1'b1;
    end else if ($signed(ef) <= 10'sd0) begin
      norm_res = {sign_q, 31'b0};
      norm_unf = 1'b1;
    end
    unique case (cls_q)
      C_NAN: begin
        norm_res = 32'h7FC00000;
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
      end
      C_INF: begin
        norm_res = {sign_q, 8'hFF, 23'b0};
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
      end
      C_ZERO: begin
        norm_res = {sign_q, 31'b0};
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ma_d    = ma_q;
    eb_d    = eb_q;
    e_d     = e_q;
    sign_d  = sign_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MUL;
          cnt_d   = 5'd0;
          sign_d  = a[31] ^ b[31];
          ma_d    = {1'b1, a[22:0]};
          p_d     = {24'b0, 1'b1, b[22:0]};
          e_d     = {2'b00, a[30:23]};
          eb_d    = b[30:23];
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            cls_d = C_NAN;
          else if (a_inf || b_inf)
            cls_d = C_INF;
          else if (a_zero || b_zero)
            cls_d = C_ZERO;
          else
            cls_d = C_NUM;
        end
      end
      S_MUL: begin
        if (p_q[0])
          p_d = {acc_c, acc_s, p_q[23:1]};
        else
          p_d = {1'b0, p_q[47:24], p_q[23:1]};
        if (cnt_q < 5'd2)
          e_d = e_sum;
        if (cnt_q == 5'd23) begin
          cnt_d   = 5'd0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_NORM: begin
        res_d   = norm_res;
        ovf_d   = norm_ovf;
        unf_d   = norm_unf;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_NUM;
      cnt_q   <= '0;
      p_q     <= '0;
      ma_q    <= '0;
      eb_q    <= '0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ma_q    <= ma_d;
      eb_q    <= eb_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign busy   = (state_q == S_MUL) || (state_q == S_NORM);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
endmodule

// File: tb/tb_fpmul_seq.sv
// Scoreboard bench for fpmul_seq: latency, handshake, rounding,
// special cases, start interference and mid-operation reset.
module tb_fpmul_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic        unf;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;
  int   done_cnt;

  fpmul_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
        chk("unf", {31'b0, unf}, {31'b0, e.unf});
      end
    end
  end

  // Cycle n is observed at the negedge just before rising edge n;
  // the accepting edge is edge 0.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] er, input logic eo,
                        input logic eu, input int p1, input int p2,
                        input int rs, input string tag);
    int dcyc;
    int dbase;
    int busy_bad;
    exp_t e;
    @(negedge clk);
    a = oa;
    b = ob;
    start = 1'b1;
    e.res = er;
    e.ovf = eo;
    e.unf = eu;
    sb.push_back(e);
    dbase = done_cnt;
    dcyc = 0;
    busy_bad = 0;
    @(posedge clk);
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      if (done && dcyc == 0) dcyc = n;
      if (rs == 0 && busy !== (n <= 25)) busy_bad++;
      if (rs != 0 && n == rs + 1) begin
        rst = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_res"}, result, 32'd0);
        chk({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
        chk({tag, "_unf"}, {31'b0, unf}, 32'd0);
      end
      if (rs != 0 && n == rs) begin
        rst = 1'b1;
        void'(sb.pop_back());
      end
      start = (n == p1) || (n == p2);
      if (start) begin
        a = oa ^ 32'h00400000;
        b = 32'h40800000;
      end
    end
    start = 1'b0;
    if (rs == 0) begin
      chk({tag, "_lat"}, dcyc, 32'd26);
      chk({tag, "_ndone"}, done_cnt - dbase, 32'd1);
      chk({tag, "_busy"}, busy_bad, 32'd0);
    end else begin
      chk({tag, "_ndone"}, done_cnt - dbase, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    done_cnt = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_unf", {31'b0, unf}, 32'd0);
    a = 32'h3FC00000;
    b = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    chk("rst_start", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    start = 1'b0;

    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 0, 0, 0, "mul3");
    run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0, 0, 0, 0, "sticky");
    run_op(32'h3F800000, 32'hBF800000, 32'hBF800000, 0, 0, 0, 0, 0, "sign");
    run_op(32'h3FC00000, 32'h3F800001, 32'h3FC00002, 0, 0, 0, 0, 0, "tie_up");
    run_op(32'h3FC00000, 32'h3F800003, 32'h3FC00004, 0, 0, 0, 0, 0, "tie_even");
    run_op(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 0, 0, 0, 0, 0, "rnd_carry");
    run_op(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1, 0, 0, 0, 0, "ovf");
    run_op(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 0, 0, "unf");
    run_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 0, 0, 0, "inf_zero");
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 0, 0, 0, "ninf");
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 0, 0, 0, 0, "nan");
    run_op(32'h80000000, 32'h3F800000, 32'h80000000, 0, 0, 0, 0, 0, "zero");
    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 5, 26, 0, "pulse");
    run_op(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, 0, 0, "after");
    run_op(32'h3F800000, 32'h40000000, 32'h40000000, 0, 0, 0, 0, 12, "abort");
    run_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0, 0, 0, 0, "fresh");

    chk("sb_left", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
